// File: rtl/reset_tick_gen_pkg.sv
// Shared definitions for the reset/tick front end: reset FSM state
// encodings, default parameter values and a counter-width helper.
package reset_tick_gen_pkg;

  typedef enum logic {
    RTG_HOLD = 1'b0,
    RTG_RUN  = 1'b1
  } rtg_state_t;

  localparam int RTG_DEBOUNCE_BITS = 16;
  localparam int RTG_HOLD_CYCLES   = 16;
  localparam int RTG_SLOW          = 21;

  // Bits needed to count 0 .. n-1, never less than one.
  function automatic int rtg_cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_tick_gen_btn_debouncer.sv
// btn_debouncer: synchronises the raw button, rejects bounces shorter than
// 2**DEBOUNCE_BITS samples and flags each debounced press with a 1-cycle pulse.
module btn_debouncer
  import reset_tick_gen_pkg::*;
#(
  parameter int DEBOUNCE_BITS = RTG_DEBOUNCE_BITS
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic btn_level,
  output logic btn_press
);

  logic                     s1;
  logic                     s2;
  logic                     level_d;
  logic [DEBOUNCE_BITS-1:0] dcnt;

  // Two-flop synchroniser; BTN is asynchronous to CLK and only s2 is used downstream.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments make s2 take the previous s1, giving two real flops.
    if (RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
    end
  end

  // Level follows s2 only after a full run of disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dcnt      <= '0;
      btn_level <= 1'b0;
    end else if (s2 == btn_level) begin
      dcnt <= '0;
    end else if (dcnt == '1) begin
      btn_level <= s2;
      dcnt      <= '0;
    end else begin
      dcnt <= dcnt + DEBOUNCE_BITS'(1);
    end
  end

  // Press pulse in the cycle after the debounced level rises; falls are not reported.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      level_d   <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      level_d   <= btn_level;
      btn_press <= btn_level & ~level_d;
    end
  end

endmodule

// File: rtl/reset_tick_gen.sv
// reset_tick_gen: debounced button, stretched active-low resetn and a slow
// 1-cycle tick enable for logic that runs entirely on CLK.
// Build option: define RESET_TICK_GEN_BTN_RESET_EN to make the debounced
// button an additional reset cause (holding it keeps resetn low).
module reset_tick_gen
  import reset_tick_gen_pkg::*;
#(
  parameter int DEBOUNCE_BITS = RTG_DEBOUNCE_BITS,
  parameter int HOLD_CYCLES   = RTG_HOLD_CYCLES,
  parameter int SLOW          = RTG_SLOW
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN,
  output logic resetn,
  output logic tick,
  output logic btn_level,
  output logic btn_press
);

  localparam int            HW        = rtg_cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  rtg_state_t      state;
  logic [HW-1:0]   hcnt;
  logic [SLOW-1:0] tcnt;
  logic            btn_cause;

  btn_debouncer #(
    .DEBOUNCE_BITS(DEBOUNCE_BITS)
  ) u_debouncer (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTN       (BTN),
    .btn_level (btn_level),
    .btn_press (btn_press)
  );

`ifdef RESET_TICK_GEN_BTN_RESET_EN
  assign btn_cause = btn_level;
`else
  assign btn_cause = 1'b0;
`endif

  // Reset FSM plus tick counter; RESET is handled first, so inside the else the only cause left is the button.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= RTG_HOLD;
      hcnt   <= '0;
      resetn <= 1'b0;
      tcnt   <= '0;
      tick   <= 1'b0;
    end else begin
      case (state)
        RTG_HOLD: begin
          tcnt <= '0;
          tick <= 1'b0;
          if (btn_cause) begin
            hcnt <= '0;
          end else if (hcnt == HOLD_LAST) begin
            state  <= RTG_RUN;
            resetn <= 1'b1;
            hcnt   <= '0;
          end else begin
            hcnt <= hcnt + HW'(1);
          end
        end
        RTG_RUN: begin
          if (btn_cause) begin
            // Leaving RUN drops the partial tick period and suppresses any pending tick.
            state  <= RTG_HOLD;
            resetn <= 1'b0;
            hcnt   <= '0;
            tcnt   <= '0;
            tick   <= 1'b0;
          end else begin
            tcnt <= tcnt + SLOW'(1);
            tick <= (tcnt == '1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_tick_gen.sv
// Self-checking bench for reset_tick_gen with DEBOUNCE_BITS=3, HOLD_CYCLES=4,
// SLOW=3. Each scenario pushes expected output vectors {resetn, tick,
// btn_level, btn_press} (with a care mask) onto a scoreboard queue, then pops
// and compares one entry per clock on the falling edge. Inputs change on the
// falling edge right after sampling; edge i means the i-th rising edge of the
// scenario.
module tb_reset_tick_gen;

  logic CLK;
  logic RESET;
  logic BTN;
  logic resetn;
  logic tick;
  logic btn_level;
  logic btn_press;

  typedef struct {
    logic [3:0] val;
    logic [3:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  reset_tick_gen #(
    .DEBOUNCE_BITS (3),
    .HOLD_CYCLES   (4),
    .SLOW          (3)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BTN       (BTN),
    .resetn    (resetn),
    .tick      (tick),
    .btn_level (btn_level),
    .btn_press (btn_press)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t mk(input logic r, input logic t, input logic l,
                              input logic p, input logic [3:0] m);
    exp_t e;
    e.val  = {r, t, l, p};
    e.mask = m;
    return e;
  endfunction

  // RESET high for 3 edges: everything low; resetn rises 4 edges after release.
  task automatic test_reset();
    exp_t e;
    logic [3:0] obs;
    RESET = 1'b1;
    BTN   = 1'b0;
    for (int i = 1; i <= 7; i++) sb.push_back(mk(i >= 7, 1'b0, 1'b0, 1'b0, 4'b1111));
    for (int i = 1; i <= 7; i++) begin
      @(negedge CLK);
      e   = sb.pop_front();
      obs = {resetn, tick, btn_level, btn_press};
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL reset edge %0d: got %b want %b (mask %b)", i, obs, e.val, e.mask);
      end
      if (i == 3) RESET = 1'b0;
    end
  endtask

  // Continues straight after test_reset: ticks 8, 16, 24 edges after resetn rose, 1 cycle wide.
  task automatic test_tick();
    exp_t e;
    logic [3:0] obs;
    for (int j = 1; j <= 25; j++) sb.push_back(mk(1'b1, (j % 8) == 0, 1'b0, 1'b0, 4'b1111));
    for (int j = 1; j <= 25; j++) begin
      @(negedge CLK);
      e   = sb.pop_front();
      obs = {resetn, tick, btn_level, btn_press};
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL tick edge %0d: got %b want %b (mask %b)", j, obs, e.val, e.mask);
      end
    end
  endtask

  // Clean press: level at edge 10, press pulse at edge 11; release: level low at 10, no press.
  task automatic test_btn_press();
    exp_t e;
    logic [3:0] obs;
    BTN = 1'b1;
    for (int i = 1; i <= 12; i++) sb.push_back(mk(1'b0, 1'b0, i >= 10, i == 11, 4'b0011));
    for (int k = 1; k <= 12; k++) sb.push_back(mk(1'b0, 1'b0, k < 10, 1'b0, 4'b0011));
    for (int i = 1; i <= 24; i++) begin
      @(negedge CLK);
      e   = sb.pop_front();
      obs = {resetn, tick, btn_level, btn_press};
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL btn_press edge %0d: got %b want %b (mask %b)", i, obs, e.val, e.mask);
      end
      if (i == 12) BTN = 1'b0;
    end
  endtask

  // High 5, low 1, high 5: the counter never completes, so level and press stay low.
  task automatic test_glitch_reject();
    exp_t e;
    logic [3:0] obs;
    BTN = 1'b1;
    for (int i = 1; i <= 20; i++) sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'b0011));
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      e   = sb.pop_front();
      obs = {resetn, tick, btn_level, btn_press};
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL glitch edge %0d: got %b want %b (mask %b)", i, obs, e.val, e.mask);
      end
      if (i == 5)  BTN = 1'b0;
      if (i == 6)  BTN = 1'b1;
      if (i == 11) BTN = 1'b0;
    end
  endtask

  // RESET at edge 11 while tcnt=5 and dcnt=4: no tick at 13, resetn back at 15, ticks at 23 and 31.
  task automatic test_reset_dominates();
    exp_t e;
    logic [3:0] obs;
    RESET = 1'b1;
    BTN   = 1'b0;
    for (int i = 1; i <= 31; i++)
      sb.push_back(mk((i >= 5 && i <= 10) || i >= 15, i == 23 || i == 31, 1'b0, 1'b0, 4'b1111));
    for (int i = 1; i <= 31; i++) begin
      @(negedge CLK);
      e   = sb.pop_front();
      obs = {resetn, tick, btn_level, btn_press};
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL reset_dominates edge %0d: got %b want %b (mask %b)", i, obs, e.val, e.mask);
      end
      if (i == 1)  RESET = 1'b0;
      if (i == 4)  BTN   = 1'b1;
      if (i == 10) RESET = 1'b1;
      if (i == 11) RESET = 1'b0;
      if (i == 14) BTN   = 1'b0;
    end
  endtask

  // Button held: level 18..39, press at 19. With the button as reset cause,
  // resetn drops at 19 and returns at 44 (tick at 52); otherwise resetn and ticks are unaffected.
  task automatic test_btn_reset();
    exp_t e;
    logic [3:0] obs;
    logic exp_r;
    logic exp_t_bit;
    RESET = 1'b1;
    BTN   = 1'b0;
    for (int i = 1; i <= 52; i++) begin
`ifdef RESET_TICK_GEN_BTN_RESET_EN
      exp_r     = (i >= 5 && i < 19) || i >= 44;
      exp_t_bit = (i == 13) || (i == 52);
`else
      exp_r     = (i >= 5);
      exp_t_bit = (i >= 13) && ((i - 5) % 8 == 0);
`endif
      sb.push_back(mk(exp_r, exp_t_bit, i >= 18 && i < 40, i == 19, 4'b1111));
    end
    for (int i = 1; i <= 52; i++) begin
      @(negedge CLK);
      e   = sb.pop_front();
      obs = {resetn, tick, btn_level, btn_press};
      n_checks++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_fail++;
        $display("FAIL btn_reset edge %0d: got %b want %b (mask %b)", i, obs, e.val, e.mask);
      end
      if (i == 1)  RESET = 1'b0;
      if (i == 8)  BTN   = 1'b1;
      if (i == 30) BTN   = 1'b0;
    end
  endtask

  initial begin
    RESET = 1'b1;
    BTN   = 1'b0;
    test_reset();
    test_tick();
    test_btn_press();
    test_glitch_reject();
    test_reset_dominates();
    test_btn_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want finish before time limit");
    $fatal(1, "simulation time limit reached");
  end

endmodule
